onehot_sequence_encoder: RTL and testbench
==========================================

# onehot_sequence_encoder

Receive-side counterpart to the rotating one-hot seconds decoder. Samples an external WIDTH-bit one-hot bus, synchronises and debounces it, and encodes each accepted value to a binary index. Checks that successive indices advance by exactly one, modulo WIDTH, and measures the clock-cycle interval between advances. Used on the monitoring side of a link to confirm that a remote one-hot seconds display is ticking correctly.

## Interface
Parameters:
- WIDTH, 8: one-hot bus width; must be a power of two, at least 2.
- STABLE_CYCLES, 4: consecutive synchronised samples required before a value is qualified; must be at least 1.
- PERIOD_W, 24: width of the interval counter and the `interval` output.

Ports:
- clk, input, 1: single clock; all logic is on its rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- onehot_in, input, WIDTH: asynchronous one-hot bus.
- index_out, output, $clog2(WIDTH): last accepted index.
- valid, output, 1: one-cycle pulse when a new index is accepted.
- invalid, output, 1: one-cycle pulse when a stable multi-hot value is qualified.
- seq_err, output, 1: one-cycle pulse, coincident with `valid`, when the accepted index is not the previous index + 1.
- locked, output, 1: high once the first index has been accepted.
- interval, output, PERIOD_W: cycles between the two most recent `valid` pulses; saturating.

## Operation
- Input path: two-flop synchroniser (sync1 → sync2), then the stability filter.
- Stability filter:
  - Counts consecutive edges on which sync2 is unchanged.
  - Any change restarts the count.
  - Issues exactly one `qual` strobe per stable episode, when the count reaches STABLE_CYCLES.
- Classification of the qualified value:
  - All-zero: idle. No outputs change.
  - Exactly one bit set: candidate index = position of that bit.
  - Two or more bits set: `invalid` pulse. No other outputs change.
- FSM states are UNLOCKED and LOCKED; reset enters UNLOCKED.
- UNLOCKED, on a one-hot qual:
  - `valid` = 1 and `index_out` ← candidate.
  - Move to LOCKED; `locked` = 1.
  - `seq_err` = 0.
  - Interval counter cleared; `interval` stays 0.
- LOCKED, on a one-hot qual:
  - If candidate == `index_out` (a glitch returned to the same value): no pulse and no state change.
  - Otherwise: `valid` = 1 and `index_out` ← candidate.
  - `seq_err` = 1 if candidate != (`index_out` + 1) mod WIDTH.
  - `interval` ← counter + 1; counter cleared.
- Interval counter:
  - Increments every cycle while LOCKED.
  - Saturates at 2^PERIOD_W − 1; `interval` reports the saturated value.
- Wrap-around: index WIDTH−1 followed by index 0 is a legal advance and raises no `seq_err`.
- There is no path back to UNLOCKED except reset.

## Timing
- Reset values:
  - All outputs are 0: `index_out`, `valid`, `invalid`, `seq_err`, `locked`, `interval`.
  - Synchroniser flops, stability count and interval counter are all 0.
- Reset is sampled at the edge. Asserting it for one edge mid-operation clears everything, including any partially counted stability episode.
- Latency: `onehot_in` changes before edge k and is then held. `valid` (or `invalid`) is high for the single cycle following edge k + STABLE_CYCLES + 1. With the default STABLE_CYCLES = 4 this is 6 edges.
- A value held for fewer than STABLE_CYCLES + 1 sampled cycles produces no pulse.
- `valid`, `invalid` and `seq_err` are registered outputs and are never high for more than one cycle per qual.
- `valid` and `invalid` are mutually exclusive.
- Interval arithmetic: inputs advancing every N cycles give `interval` == N from the second `valid` onward, updated in the same cycle as `valid`.

## Structure
- Package `onehot_seq_pkg` holds:
  - the FSM enum (UNLOCKED, LOCKED);
  - the index-width constant derived from WIDTH via `$clog2`.
- Sub-module `onehot_stable_filter` contains the synchroniser, stability counter and `qual` strobe.
  - Parameterised by WIDTH and STABLE_CYCLES.
  - Outputs the stable value and `qual`.
- Top level holds the encoder and classification logic, the FSM, the sequence check and the interval counter.

## Test plan
- Reset with `onehot_in` = 8'h00 for 50 cycles → no pulses; `locked` = 0, `index_out` = 0, `interval` = 0.
- Drive 8'h01 from edge 10 and hold → `valid` high for one cycle following edge 15; `index_out` = 0, `locked` = 1, `seq_err` = 0.
- Step 01, 02, 04 … 80, 01, each value held 100 cycles → `valid` on every step, `interval` = 100 from the second step on, `seq_err` never high (including the 80→01 wrap).
- While locked at 8'h04, drive 8'h10 → `index_out` = 4, `valid` and `seq_err` pulse together.
- While locked at 8'h04:
  - a 3-cycle glitch to 8'h08 → no pulse;
  - 8'h03 held → exactly one `invalid` pulse; `index_out` and `locked` unchanged.
- With PERIOD_W = 4, advance after 40 cycles → `interval` = 15. Then assert `rst_n` = 0 for one cycle → all outputs 0 at the next edge.

Source files
------------

// File: rtl/onehot_seq_pkg.sv
// Shared definitions for the one-hot sequence encoder.
//   - lock_state_e : two-state lock FSM encoding (UNLOCKED, LOCKED)
//   - index_width(): binary index width for a given one-hot bus width
//   - DEFAULT_WIDTH / DEFAULT_INDEX_W : constants for the default 8-bit bus
package onehot_seq_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Index width for a WIDTH-bit one-hot bus (never narrower than one bit).
    function automatic int index_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_INDEX_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/onehot_stable_filter.sv
// Two-flop synchroniser followed by a stability filter.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   din        : asynchronous WIDTH-bit input bus
//   stable_out : synchronised value (valid as the qualified value while qual=1)
//   qual       : one-cycle strobe, once per stable episode, presented in the
//                cycle whose closing edge brings the stability count to
//                STABLE_CYCLES
module onehot_stable_filter #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable_out,
    output logic             qual
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE    = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             same;

    // sync1_q is the value sync2 takes at the next edge, so comparing the two
    // tells us whether that edge leaves sync2 unchanged.
    assign same = (sync1_q == sync2_q);

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_TARGET) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The count holds at the target, so the strobe fires once per episode.
    assign qual       = same && (cnt_q == CNT_PRE);
    assign stable_out = sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/onehot_sequence_encoder.sv
// Receive-side monitor for a rotating one-hot seconds bus. Synchronises and
// debounces the bus, encodes each qualified one-hot value to an index, checks
// that indices advance by one (mod WIDTH) and measures the interval between
// advances.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   onehot_in : asynchronous WIDTH-bit one-hot bus
//   index_out : last accepted index
//   valid     : one-cycle pulse when a new index is accepted
//   invalid   : one-cycle pulse when a stable multi-hot value is qualified
//   seq_err   : pulse with valid when the index did not advance by exactly one
//   locked    : high once the first index has been accepted
//   interval  : cycles between the two most recent valid pulses (saturating)
module onehot_sequence_encoder
    import onehot_seq_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              onehot_in,
    output logic [index_width(WIDTH)-1:0] index_out,
    output logic                          valid,
    output logic                          invalid,
    output logic                          seq_err,
    output logic                          locked,
    output logic [PERIOD_W-1:0]           interval
);

    localparam int IDX_W = index_width(WIDTH);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] stable_val;
    logic             qual;

    onehot_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (onehot_in),
        .stable_out (stable_val),
        .qual       (qual)
    );

    // Classification: clearing the lowest set bit leaves something only when
    // two or more bits are set.
    logic             is_zero;
    logic             is_multi;
    logic [IDX_W-1:0] cand;

    assign is_zero  = (stable_val == '0);
    assign is_multi = ((stable_val & (stable_val - WIDTH'(1))) != '0);

    // OR-based encoder; only meaningful when the value is one-hot.
    always_comb begin
        cand = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (stable_val[i]) begin
                cand = cand | IDX_W'(i);
            end
        end
    end

    lock_state_e         state_q, state_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                valid_q, valid_d;
    logic                invalid_q, invalid_d;
    logic                seq_err_q, seq_err_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] interval_q, interval_d;
    logic [PERIOD_W-1:0] cnt_plus1_sat;

    // Interval including the edge that accepts the new index.
    assign cnt_plus1_sat = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + PERIOD_W'(1));

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        valid_d    = 1'b0;
        invalid_d  = 1'b0;
        seq_err_d  = 1'b0;
        interval_d = interval_q;
        cnt_d      = cnt_q;

        if (state_q == LOCKED && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end

        if (qual && !is_zero) begin
            if (is_multi) begin
                invalid_d = 1'b1;
            end else begin
                unique case (state_q)
                    UNLOCKED: begin
                        valid_d = 1'b1;
                        index_d = cand;
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end
                    LOCKED: begin
                        // A return to the current index is a glitch recovery.
                        if (cand != index_q) begin
                            valid_d    = 1'b1;
                            index_d    = cand;
                            // Power-of-two WIDTH makes the IDX_W add wrap mod WIDTH.
                            seq_err_d  = (cand != (index_q + IDX_W'(1)));
                            interval_d = cnt_plus1_sat;
                            cnt_d      = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            index_q    <= '0;
            valid_q    <= 1'b0;
            invalid_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            cnt_q      <= '0;
            interval_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            invalid_q  <= invalid_d;
            seq_err_q  <= seq_err_d;
            cnt_q      <= cnt_d;
            interval_q <= interval_d;
        end
    end

    assign index_out = index_q;
    assign valid     = valid_q;
    assign invalid   = invalid_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == LOCKED);
    assign interval  = interval_q;

endmodule

// File: tb/tb_onehot_sequence_encoder.sv
module tb_onehot_sequence_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in1, in2;

    logic [2:0]  index_out, d2_index;
    logic        valid, invalid, seq_err, locked;
    logic        d2_valid, d2_invalid, d2_seq_err, d2_locked;
    logic [23:0] interval;
    logic [3:0]  d2_interval;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit is_inv;
        int idx;
        bit serr;
        int intv;
        int cyc;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onehot_sequence_encoder #(.WIDTH(8), .STABLE_CYCLES(4), .PERIOD_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .onehot_in (in1),
        .index_out (index_out),
        .valid     (valid),
        .invalid   (invalid),
        .seq_err   (seq_err),
        .locked    (locked),
        .interval  (interval)
    );

    onehot_sequence_encoder #(.WIDTH(8), .STABLE_CYCLES(4), .PERIOD_W(4)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .onehot_in (in2),
        .index_out (d2_index),
        .valid     (d2_valid),
        .invalid   (d2_invalid),
        .seq_err   (d2_seq_err),
        .locked    (d2_locked),
        .interval  (d2_interval)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s = %0d", nm, act);
        end
    endtask

    // Drive a value at the current falling edge and hold it. When push is set,
    // the expected pulse is queued: first sampling edge k, pulse after edge k+5.
    task automatic step(input logic [7:0] v, input int hold, input bit push,
                        input bit inv, input int idx, input bit serr, input int intv);
        exp_t e;
        in1 = v;
        if (push) begin
            e.is_inv = inv;
            e.idx    = idx;
            e.serr   = serr;
            e.intv   = intv;
            e.cyc    = cyc + 1 + 5;
            sb_q.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    // Monitor: one line per observed pulse, compared against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (valid && invalid) begin
            errors++; checks++;
            $display("FAIL excl: valid=%0d invalid=%0d required not both", valid, invalid);
        end
        if (seq_err && !valid) begin
            errors++; checks++;
            $display("FAIL seq_err_alone: seq_err=1 valid=0 required seq_err only with valid");
        end
        if (valid || invalid) begin
            if (sb_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL unexpected_pulse: cyc=%0d valid=%0d invalid=%0d idx=%0d required no pulse",
                         cyc, valid, invalid, index_out);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (invalid != e.is_inv || int'(index_out) != e.idx || seq_err != e.serr ||
                    int'(interval) != e.intv || cyc != e.cyc || locked != 1'b1) begin
                    errors++;
                    $display("FAIL pulse: got inv=%0d idx=%0d serr=%0d intv=%0d cyc=%0d lock=%0d required inv=%0d idx=%0d serr=%0d intv=%0d cyc=%0d lock=1",
                             invalid, index_out, seq_err, interval, cyc, locked,
                             e.is_inv, e.idx, e.serr, e.intv, e.cyc);
                end else begin
                    $display("ok   pulse inv=%0d idx=%0d serr=%0d intv=%0d cyc=%0d",
                             invalid, index_out, seq_err, interval, cyc);
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   k2;
        bit   seen;

        rst_n = 1'b0;
        in1   = 8'h00;
        in2   = 8'h00;
        repeat (50) @(negedge clk);
        chk("rst_index",    index_out, 0);
        chk("rst_locked",   locked,    0);
        chk("rst_interval", interval,  0);
        chk("rst_valid",    valid | invalid | seq_err, 0);

        rst_n = 1'b1;
        repeat (9) @(negedge clk);

        // First lock, then a full rotation including the 80 -> 01 wrap.
        step(8'h01, 100, 1, 0, 0, 0, 0);
        chk("lock_after_first", locked, 1);
        for (int j = 1; j < 8; j++) begin
            step(8'h01 << j, 100, 1, 0, j, 0, 100);
        end
        step(8'h01, 100, 1, 0, 0, 0, 100);
        step(8'h02, 100, 1, 0, 1, 0, 100);
        step(8'h04, 100, 1, 0, 2, 0, 100);

        // Skip 04 -> 10, then 10 -> 04 (also not +1).
        step(8'h10, 100, 1, 0, 4, 1, 100);
        step(8'h04, 100, 1, 0, 2, 1, 100);

        // Glitches shorter than STABLE_CYCLES+1 samples: no pulse.
        step(8'h08, 3,   0, 0, 0, 0, 0);
        step(8'h04, 100, 0, 0, 0, 0, 0);
        step(8'h08, 4,   0, 0, 0, 0, 0);
        step(8'h04, 100, 0, 0, 0, 0, 0);

        // Multi-hot: one invalid pulse, index and interval unchanged.
        step(8'h03, 100, 1, 1, 2, 0, 100);
        // Back to the same index: no pulse.
        step(8'h04, 50, 0, 0, 0, 0, 0);
        chk("after_invalid_index",  index_out, 2);
        chk("after_invalid_locked", locked,    1);

        // Saturating interval on the PERIOD_W=4 instance.
        in2 = 8'h01;
        repeat (40) @(negedge clk);
        in2 = 8'h02;
        k2 = cyc + 1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (d2_valid) begin
                seen = 1'b1;
                chk("sat_interval", d2_interval, 15);
                chk("sat_index",    d2_index,    1);
                chk("sat_seq_err",  d2_seq_err,  0);
                chk("sat_cycle",    cyc,         k2 + 5);
            end
        end
        if (!seen) begin
            errors++; checks++;
            $display("FAIL sat_timeout: no valid on PERIOD_W=4 instance within 20 cycles");
        end

        // One-edge reset mid-operation.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_index",     index_out,   0);
        chk("rst2_locked",    locked,      0);
        chk("rst2_interval",  interval,    0);
        chk("rst2_pulses",    valid | invalid | seq_err, 0);
        chk("rst2_d2_interval", d2_interval, 0);
        chk("rst2_d2_locked", d2_locked,   0);
        chk("rst2_d2_index",  d2_index,    0);
        // Input still 04: it must requalify from scratch as a fresh lock.
        e.is_inv = 1'b0; e.idx = 2; e.serr = 1'b0; e.intv = 0; e.cyc = cyc + 1 + 5;
        sb_q.push_back(e);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("relock_locked", locked, 1);

        for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++; checks++;
            $display("FAIL missing_pulse: %0d expected pulses never seen, required 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
